// File: rtl/posit_pkg.sv
// Shared posit constants and stage bundles for the encoder, decoder and multiplier.
// No ports; import with posit_pkg::*.
package posit_pkg;

    localparam int N   = 8;
    localparam int ES  = 2;
    localparam int FW  = 8;
    localparam int SW  = 8;

    // magnitude width (posit without its sign bit)
    localparam int RW  = N - 1;
    // regime + exponent + fraction staging field
    localparam int FLW = N - 1 + ES + FW + 2;
    // regime shift amount width; covers every non-saturating k
    localparam int SHW = $clog2(N - 1);

    localparam logic [N-1:0] ZERO   = '0;
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = N'(1);

    typedef struct packed {
        logic           sign;
        logic           zero;
        logic           nar;
        logic           sat_hi;
        logic           sat_lo;
        logic           k_neg;
        logic [SHW-1:0] amt;
        logic [ES-1:0]  e;
        logic [FW-1:0]  frac;
        logic           sticky;
    } s1_t;

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic          nar;
        logic [RW-1:0] mag;
    } s2_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on a truncated posit magnitude, clamped to [minpos, maxpos].
// Ports: mag_trunc/guard/sticky in, mag_round out (combinational).
module posit_round_rne
    import posit_pkg::*;
(
    input  logic [RW-1:0] mag_trunc,
    input  logic          guard,
    input  logic          sticky,
    output logic [RW-1:0] mag_round
);

    logic        round_up;
    logic [RW:0] sum;

    assign round_up = guard & (sticky | mag_trunc[0]);
    assign sum      = {1'b0, mag_trunc} + {{RW{1'b0}}, round_up};

    // Posits never round to zero and never overflow into NaR.
    always_comb begin
        mag_round = sum[RW-1:0];
        if (sum[RW])
            mag_round = MAXPOS[RW-1:0];
        else if (sum[RW-1:0] == '0)
            mag_round = MINPOS[RW-1:0];
    end

endmodule

// File: rtl/posit_encode.sv
// Three-stage posit packer: decode regime, shift+round, negate. Valid/ready both sides.
// Ports: clk, reset, in_* (unpacked value + handshake), out_* (posit + handshake).
module posit_encode
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic          in_zero,
    input  logic          in_nar,
    input  logic [SW-1:0] in_scale,
    input  logic [FW-1:0] in_frac,
    input  logic          in_sticky,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_posit
);

    localparam logic signed [SW-1:0] K_MAX = SW'(N - 2);
    localparam logic signed [SW-1:0] K_MIN = -K_MAX;

    logic adv;
    logic s1_valid;
    logic s2_valid;
    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  s2_d;
    s2_t  s2_q;

    logic signed [SW-1:0] k;

    logic [FLW-1:0] base;
    logic [FLW-1:0] field;
    logic [RW-1:0]  mag_trunc;
    logic [RW-1:0]  mag_rnd;
    logic           guard;
    logic           sticky;

    logic [N-1:0] mag_full;
    logic [N-1:0] out_d;

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // S1: split scale into regime k and exponent e.
    assign k = $signed(in_scale) >>> ES;

    always_comb begin
        s1_d        = '0;
        s1_d.sign   = in_sign;
        s1_d.zero   = in_zero;
        s1_d.nar    = in_nar;
        s1_d.sat_hi = k >= K_MAX;
        s1_d.sat_lo = k <= K_MIN;
        s1_d.k_neg  = k[SW-1];
        // k>=0 needs k extra ones; k<0 needs -k-1 extra zeros (= ~k).
        s1_d.amt    = k[SW-1] ? ~k[SHW-1:0] : k[SHW-1:0];
        s1_d.e      = in_scale[ES-1:0];
        s1_d.frac   = in_frac;
        s1_d.sticky = in_sticky;
    end

    // S2: the head's top bit is replicated by the arithmetic shift,
    // growing the regime run to its full length.
    assign base = {
        (s1_q.k_neg ? 2'b01 : 2'b10),
        s1_q.e,
        s1_q.frac,
        {(FLW-2-ES-FW){1'b0}}
    };

    assign field     = $unsigned($signed(base) >>> s1_q.amt);
    assign mag_trunc = field[FLW-1 -: RW];
    assign guard     = field[FLW-1-RW];
    assign sticky    = (|field[FLW-2-RW:0]) | s1_q.sticky;

    posit_round_rne u_round (
        .mag_trunc (mag_trunc),
        .guard     (guard),
        .sticky    (sticky),
        .mag_round (mag_rnd)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.nar  = s1_q.nar;
        if (s1_q.sat_hi)
            s2_d.mag = MAXPOS[RW-1:0];
        else if (s1_q.sat_lo)
            s2_d.mag = MINPOS[RW-1:0];
        else
            s2_d.mag = mag_rnd;
    end

    // S3: specials, then sign by two's-complement negate.
    assign mag_full = {1'b0, s2_q.mag};

    always_comb begin
        out_d = mag_full;
        if (s2_q.nar)
            out_d = NAR;
        else if (s2_q.zero)
            out_d = ZERO;
        else if (s2_q.sign)
            out_d = -mag_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_posit <= ZERO;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid)
                out_posit <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            if (in_valid)
                s1_q <= s1_d;
            if (s1_valid)
                s2_q <= s2_d;
        end
    end

endmodule

// File: tb/tb_posit_encode.sv
// Random + directed bench for posit_encode against an arithmetic posit model.
// No ports.
module tb_posit_encode;
    import posit_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic          in_zero;
    logic          in_nar;
    logic [SW-1:0] in_scale;
    logic [FW-1:0] in_frac;
    logic          in_sticky;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_posit;

    always #5 clk = ~clk;

    posit_encode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .in_sticky (in_sticky),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sent     = 0;
    int outs     = 0;
    int dropped  = 0;
    bit lat_mode = 1'b1;
    logic [7:0] last_out = '0;

    logic [7:0] exp_q[$];
    int         acc_q[$];
    bit         lat_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Build the posit as a bit string, then round by comparing the
    // discarded tail against one half ulp.
    function automatic logic [7:0] ref_posit(input bit sgn, input bit zro,
                                             input bit nr, input int scale,
                                             input int frac, input bit stk);
        longint bits = 0;
        longint rem;
        longint half;
        int len = 0;
        int k;
        int e;
        int mag;
        int cut;
        if (nr) return 8'h80;
        if (zro) return 8'h00;
        k = (scale >= 0) ? scale / 4 : -((-scale + 3) / 4);
        e = scale - 4 * k;
        if (k >= 6) mag = 127;
        else if (k <= -6) mag = 1;
        else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin bits = bits * 2 + 1; len++; end
                bits = bits * 2; len++;
            end else begin
                for (int i = 0; i < -k; i++) begin bits = bits * 2; len++; end
                bits = bits * 2 + 1; len++;
            end
            bits = bits * 4 + e;     len += 2;
            bits = bits * 256 + frac; len += 8;
            cut  = len - 7;
            mag  = int'(bits >> cut);
            rem  = bits - (longint'(mag) << cut);
            half = longint'(1) << (cut - 1);
            if (rem > half || (rem == half && (stk || (mag % 2) == 1)))
                mag++;
            if (mag > 127) mag = 127;
            if (mag == 0) mag = 1;
        end
        return sgn ? 8'((256 - mag) & 255) : 8'(mag);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs and outputs are looked at mid-cycle; whatever handshakes
    // hold here complete on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            dropped += exp_q.size();
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
        end else begin
            check_eq("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("stale_out", out_valid, 0);
                end else begin
                    check_eq("out_posit", out_posit, exp_q[0]);
                    if (out_ready) begin
                        if (lat_q[0])
                            check_eq("latency", cyc - acc_q[0], 3);
                        last_out = out_posit;
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        void'(lat_q.pop_front());
                        outs++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_posit(in_sign, in_zero, in_nar,
                                          int'($signed(in_scale)),
                                          int'(in_frac), in_sticky));
                acc_q.push_back(cyc);
                lat_q.push_back(lat_mode);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit sgn, input bit zro, input bit nr,
                        input int sc, input int fr, input bit stk);
        bit ok;
        int tries = 0;
        in_valid  = 1'b1;
        in_sign   = sgn;
        in_zero   = zro;
        in_nar    = nr;
        in_scale  = SW'(sc);
        in_frac   = FW'(fr);
        in_sticky = stk;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!ok && tries < 100);
        if (ok) sent++;
        else check_eq("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic              s;
        logic              z;
        logic              n;
        logic signed [7:0] sc;
        logic [7:0]        fr;
        logic              st;
        logic [7:0]        ex;
    } vec_t;

    vec_t vecs[16] = '{
        '{1'b0, 1'b0, 1'b0,  8'sd0,    8'h00, 1'b0, 8'h40},
        '{1'b0, 1'b0, 1'b0,  8'sd1,    8'h00, 1'b0, 8'h48},
        '{1'b0, 1'b0, 1'b0,  8'sd4,    8'h00, 1'b0, 8'h60},
        '{1'b0, 1'b0, 1'b0, -8'sd1,    8'h00, 1'b0, 8'h38},
        '{1'b0, 1'b0, 1'b0,  8'sd0,    8'h80, 1'b0, 8'h44},
        '{1'b1, 1'b0, 1'b0,  8'sd0,    8'h00, 1'b0, 8'hC0},
        '{1'b1, 1'b1, 1'b0,  8'sd0,    8'h00, 1'b0, 8'h00},
        '{1'b0, 1'b1, 1'b1,  8'sd0,    8'h00, 1'b0, 8'h80},
        '{1'b0, 1'b0, 1'b0,  8'sd0,    8'h10, 1'b0, 8'h40},
        '{1'b0, 1'b0, 1'b0,  8'sd0,    8'h30, 1'b0, 8'h42},
        '{1'b0, 1'b0, 1'b0,  8'sd0,    8'h10, 1'b1, 8'h41},
        '{1'b0, 1'b0, 1'b0,  8'sd24,   8'h00, 1'b0, 8'h7F},
        '{1'b0, 1'b0, 1'b0,  8'sd100,  8'h00, 1'b0, 8'h7F},
        '{1'b0, 1'b0, 1'b0, -8'sd24,   8'h00, 1'b0, 8'h01},
        '{1'b0, 1'b0, 1'b0, -8'sd100,  8'h00, 1'b0, 8'h01},
        '{1'b1, 1'b0, 1'b0,  8'sd100,  8'h00, 1'b0, 8'h81}
    };

    task automatic send_rand();
        int sc;
        if ($urandom_range(0, 3) == 0) sc = int'($urandom_range(0, 255)) - 128;
        else sc = int'($urandom_range(0, 60)) - 30;
        send($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
             $urandom_range(0, 31) == 0, sc, int'($urandom_range(0, 255)),
             $urandom_range(0, 1) == 1);
    endtask

    bit rnd_done = 1'b0;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_zero   = 1'b0;
        in_nar    = 1'b0;
        in_scale  = '0;
        in_frac   = '0;
        in_sticky = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_posit", out_posit, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            send(vecs[i].s, vecs[i].z, vecs[i].n, int'(vecs[i].sc),
                 int'(vecs[i].fr), vecs[i].st);
            in_valid = 1'b0;
            wait_drain();
            check_eq($sformatf("dir%0d", i), last_out, vecs[i].ex);
        end

        // backpressure mid-stream
        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // reset with three beats in flight
        lat_mode = 1'b1;
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 0);
        repeat (6) @(posedge clk);
        #1;
        send(1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        in_valid = 1'b0;
        wait_drain();
        check_eq("post_rst_beat", last_out, 8'h48);

        // random traffic with random downstream stalls
        lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = $urandom_range(0, 3) != 0;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        check_eq("beat_count", outs + dropped, sent);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/posit_encode.md
Name: posit_encode

Overview:
Pipelined posit encoder. It is the inverse of the team's posit field decoder: it takes an unpacked value (sign, signed scale, fraction, sticky) and packs it into an N-bit posit (ES exponent bits), with variable-length regime, round-to-nearest-even and saturation. It sits at the output of the posit multiplier/adder datapaths, replacing their fixed-regime packing. Valid/ready streaming on both sides.

Parameters:
N, 8, posit word width
ES, 2, exponent field width
FW, 8, input fraction width (hidden bit excluded, MSB-aligned)
SW, 8, signed scale width (scale = k*2^ES + e)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  encoder accepts beat
in_sign  in  1  value sign
in_zero  in  1  value is exactly zero
in_nar  in  1  value is NaR (overrides in_zero)
in_scale  in  SW  signed binary scale
in_frac  in  FW  fraction bits below the hidden 1
in_sticky  in  1  OR of discarded bits below in_frac
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_posit  out  N  encoded posit, two's complement when negative

Behaviour:
- Reset: out_valid=0, out_posit=0, all stage valids=0; in_ready=1 in the first cycle after reset deasserts. Reset mid-stream drops all in-flight beats.
- Pipeline: 3 registered stages (S1 decode, S2 shift+round, S3 negate/output). Latency is 3 cycles from accept to out_valid with no backpressure. Throughput 1/cycle.
- Advance enable: adv = ~out_valid | out_ready. in_ready = adv. When adv=0, all stages hold. No bubble collapsing is required. Beat accepted iff in_valid & in_ready. Output transferred iff out_valid & out_ready. out_posit is stable while out_valid & ~out_ready.
- S1: k = in_scale >>> ES (arithmetic), e = in_scale[ES-1:0].
  - Saturation flags: sat_hi if k >= N-2; sat_lo if k <= -(N-2).
  - Regime run length: k+1 ones then 0 for k>=0; -k zeros then 1 for k<0.
- S2: form {regime, e, in_frac} MSB-first in an (N-1+ES+FW+2)-bit field. Keep the top N-1 bits. guard = next bit; sticky = OR(remaining bits, in_sticky).
  - Round up iff guard & (sticky | lsb). A carry ripples through the exponent into the regime, which is correct posit behaviour.
  - The rounded magnitude never becomes 0 and never exceeds maxpos. A magnitude of 0 after truncation becomes minpos (0…01). Overflow is clamped to maxpos (01…1).
  - sat_hi forces maxpos and sat_lo forces minpos, regardless of fraction.
- S3: if in_sign, out = {1, two's-complement negation of the magnitude}, i.e. the full N-bit negate of {0,mag}. Otherwise out = {0,mag}.
  - in_nar → out = 1 followed by N-1 zeros.
  - in_zero (and not in_nar) → out = 0. Sign is ignored in both cases.
- Simultaneous accept and output on the same cycle is legal and sustains full throughput.

Decomposition:
- Shared package posit_pkg: N, ES, derived widths (RW=N-1, field width), constants MAXPOS, MINPOS, NAR, ZERO. The decoder and multiplier share these.
- One sub-module: posit_round_rne (combinational; inputs: truncated magnitude, guard, sticky; output: rounded, clamped magnitude). It is reusable by the adder.
- Stage registers and handshake stay in posit_encode.

Test Plan:
- scale=0, frac=0x00 → 0x40. scale=1 → 0x48. scale=4 → 0x60. scale=-1 → 0x38. scale=0 with frac=0x80 (1.5) → 0x44. Each out_valid exactly 3 cycles after accept.
- sign=1, scale=0, frac=0 → 0xC0. in_zero=1 with sign=1 → 0x00. in_nar=1 with in_zero=1 → 0x80.
- Rounding at scale=0: frac=0x10, sticky=0 → 0x40 (tie to even, down). frac=0x30 → 0x42 (tie, up). frac=0x10, sticky=1 → 0x41.
- Saturation: scale=24 → 0x7F; scale=100 → 0x7F; scale=-24 → 0x01; scale=-100 → 0x01; sign=1 with scale=100 → 0x81.
- Backpressure: stream 6 beats with out_ready low for 4 cycles mid-stream. No loss or duplication, order preserved, out_posit stable while stalled, in_ready equals adv.
- Assert reset while 3 beats are in flight → out_valid=0 the next cycle and no stale beat emerges afterwards. The first post-reset beat appears 3 cycles after its accept.
